// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM geometry plus the fill engine's mode and state encodings.
package gpu_pkg;
  localparam int VRAM_ADDR_WIDTH = 12;
  localparam int VRAM_SIZE       = 1 << VRAM_ADDR_WIDTH;
  localparam int VRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    FILL_CONST  = 2'd0,
    FILL_RAMP   = 2'd1,
    FILL_STREAM = 2'd2
  } fill_mode_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_FIN  = 2'd2
  } fill_state_t;

  // The reserved encoding falls back to a constant fill.
  function automatic fill_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return FILL_RAMP;
      2'd2:    return FILL_STREAM;
      default: return FILL_CONST;
    endcase
  endfunction
endpackage

// File: rtl/fill_ramp_gen_m.sv
// Ramp accumulator: load latches start/step, advance adds step; value is registered (0-cycle read).
// No backpressure of its own; the owner simply withholds advance while stalled.
module fill_ramp_gen_m #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] start,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] value
);
  logic [WIDTH-1:0] step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value  <= '0;
      step_q <= '0;
    end else if (load) begin
      value  <= start;
      step_q <= step;
    end else if (advance) begin
      value <= value + step_q;
    end
  end
endmodule

// File: rtl/vram_fill_engine_m.sv
// Command-driven VRAM fill (const/ramp/stream); first write request 1 cycle after accept, done 1 cycle after last commit.
// Stalls with all state held while wr_grant is low or the stream source is empty.
module vram_fill_engine_m
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_value,
  input  logic [DATA_WIDTH-1:0] cmd_step,
  input  logic                  abort,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  wr_grant,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);
  localparam logic [1:0] ST_IDLE = FS_IDLE;
  localparam logic [1:0] ST_RUN  = FS_RUN;
  localparam logic [1:0] ST_FIN  = FS_FIN;

  logic [1:0]            state;
  fill_mode_t            mode_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] ramp_value;
  logic                  aborted_q;
  logic                  accept;
  logic                  run;
  logic                  commit;
  logic                  last;

  always_comb begin
    accept       = (state == ST_IDLE) && cmd_valid;
    run          = (state == ST_RUN);
    write_enable = run && ((mode_q != FILL_STREAM) || src_valid);
    commit       = write_enable && wr_grant;
    last         = commit && (remaining == LEN_WIDTH'(1));
    src_ready    = run && (mode_q == FILL_STREAM) && src_valid && wr_grant;
    data         = '0;
    if (run) begin
      case (mode_q)
        FILL_RAMP:   data = ramp_value;
        FILL_STREAM: data = src_data;
        default:     data = value_q;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = run;
  assign done      = (state == ST_FIN);
  assign aborted   = aborted_q;
  assign address   = ptr;

  fill_ramp_gen_m #(
    .WIDTH(DATA_WIDTH)
  ) u_ramp (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .advance(commit),
    .start  (cmd_value),
    .step   (cmd_step),
    .value  (ramp_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= FILL_CONST;
      ptr       <= '0;
      remaining <= '0;
      value_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            mode_q    <= decode_mode(cmd_mode);
            ptr       <= cmd_base;
            remaining <= cmd_len;
            value_q   <= cmd_value;
            aborted_q <= 1'b0;
            state     <= (cmd_len == '0) ? ST_FIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (commit) begin
            ptr       <= ptr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
          end
          // A final commit wins over a simultaneous abort: the command did complete.
          if (last) begin
            state <= ST_FIN;
          end else if (abort) begin
            state     <= ST_FIN;
            aborted_q <= 1'b1;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_fill_engine_m.sv
// Scoreboard bench for vram_fill_engine_m: drivers push expected writes/completions, a negedge monitor checks them.
module tb_vram_fill_engine_m;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_mode = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_value = '0;
  logic [DW-1:0] cmd_step = '0;
  logic          abort = 1'b0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          wr_grant = 1'b0;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          write_enable;
  logic          busy;
  logic          done;
  logic          aborted;

  vram_fill_engine_m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_value(cmd_value), .cmd_step(cmd_step),
    .abort(abort), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .wr_grant(wr_grant), .address(address), .data(data), .write_enable(write_enable),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic ab; int n; } dn_t;

  wr_t        wq[$];
  dn_t        dq[$];
  logic [7:0] fixed_bytes[$];
  dn_t        de;
  int         checks = 0;
  int         failures = 0;
  int         ncommit = 0;
  logic       cur_stream = 1'b0;
  logic       mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every presented request against the head of the expected write stream.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (write_enable) begin
        if (wq.size() == 0) chk("spurious_write", 1, 0);
        else begin
          chk("wr_addr", address, wq[0].a);
          chk("wr_data", data, wq[0].d);
          if (wr_grant) begin
            void'(wq.pop_front());
            ncommit++;
          end
        end
      end
      if (busy && cur_stream) chk("src_ready", src_ready, src_valid && wr_grant);
      else chk("src_ready_quiet", src_ready, 0);
      if (done) begin
        if (dq.size() == 0) chk("spurious_done", 1, 0);
        else begin
          de = dq.pop_front();
          chk("aborted", aborted, de.ab);
          chk("write_count", ncommit, de.n);
          wq.delete();
          ncommit = 0;
        end
      end
    end
  end

  task automatic run_cmd(input int mode, input int base, input int len, input int value,
                         input int step, input int abort_cyc, input logic [31:0] gpat,
                         input logic [31:0] vpat, input int plen, input int gpct, input int vpct);
    logic [7:0] bytes[$];
    int   emode, cyc, commits;
    logic g, v, fin;
    wr_t  w;
    emode = (mode == 3) ? 0 : mode;
    for (int k = 0; k < len; k++) begin
      if (fixed_bytes.size() > 0) bytes.push_back(fixed_bytes.pop_front());
      else bytes.push_back(8'($urandom));
    end
    fixed_bytes.delete();
    for (int k = 0; k < len; k++) begin
      w.a = AW'(base + k);
      case (emode)
        1:       w.d = DW'(value + step * k);
        2:       w.d = bytes[k];
        default: w.d = DW'(value);
      endcase
      wq.push_back(w);
    end
    cur_stream = (emode == 2);
    cmd_mode = 2'(mode); cmd_base = AW'(base); cmd_len = LW'(len);
    cmd_value = DW'(value); cmd_step = DW'(step);
    cmd_valid = 1'b1;
    abort = 1'($urandom % 2);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    if (len == 0) begin
      dq.push_back('{1'b0, 0});
      chk("done_len0", done, 1);
      chk("we_len0", write_enable, 0);
    end else begin
      cyc = 0; commits = 0; fin = 1'b0;
      while (!fin) begin
        if (cyc < plen) begin g = gpat[cyc]; v = vpat[cyc]; end
        else begin g = ($urandom_range(99) < gpct); v = ($urandom_range(99) < vpct); end
        wr_grant = g; src_valid = v;
        src_data = v ? bytes[commits] : 8'($urandom);
        abort = (cyc == abort_cyc);
        cmd_valid = ($urandom % 4 == 0);
        chk("busy_run", busy, 1);
        chk("ready_run", cmd_ready, 0);
        @(posedge clk); #1;
        if (g && (emode != 2 || v)) commits++;
        if (commits == len || abort) fin = 1'b1;
        cyc++;
        if (!fin && cyc > 400) begin chk("run_timeout", 0, 1); fin = 1'b1; end
      end
      abort = 1'b0;
      dq.push_back('{(commits != len), commits});
      chk("done_fin", done, 1);
      chk("we_fin", write_enable, 0);
      chk("ready_fin", cmd_ready, 0);
    end
    cmd_valid = 1'($urandom % 2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("ready_after", cmd_ready, 1);
    chk("done_after", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, mode, ac;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_addr", address, 0);
    chk("rst_data", data, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_srcrdy", src_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_cmd(0, 'h400, 4, 'hA5, 0, -1, '1, '0, 32, 100, 100);
    run_cmd(1, 'hFFE, 4, 'hFE, 1, -1, '1, '0, 32, 100, 100);
    fixed_bytes = '{8'h11, 8'h22, 8'h33};
    run_cmd(2, 'h800, 3, 0, 0, -1, '1, 32'b1101, 4, 100, 100);
    run_cmd(0, 'h123, 3, 'h5C, 0, -1, 32'b11001, '0, 5, 100, 100);
    run_cmd(0, 'h010, 8, 'h77, 0, 1, '1, '0, 32, 100, 100);
    run_cmd(1, 'h020, 2, 'h10, 3, 1, '1, '0, 32, 100, 100);
    run_cmd(0, 'h300, 0, 'h99, 0, -1, '1, '0, 32, 100, 100);
    run_cmd(3, 'h7F0, 5, 'h3C, 7, -1, '1, '0, 32, 60, 100);

    // Reset in the middle of a command: no completion may follow.
    for (int k = 0; k < 8; k++) wq.push_back('{AW'('h500 + k), 8'h42});
    cur_stream = 1'b0;
    cmd_mode = 2'd0; cmd_base = AW'('h500); cmd_len = LW'(8); cmd_value = 8'h42;
    wr_grant = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_addr", address, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_we", write_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_aborted", aborted, 0);
    wq.delete();
    ncommit = 0;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_done", done, 0);
    end

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      len = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 20);
      ac = ($urandom % 4 == 0) ? $urandom_range(0, len + 3) : -1;
      run_cmd(mode, $urandom_range(0, 4095), len, $urandom_range(0, 255),
              $urandom_range(0, 255), ac, '0, '0, 0, 70, 70);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_wq_empty", wq.size(), 0);
    chk("final_dq_empty", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
